// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among four requesters.
// Optional build macro RF_ARB_ZERO_FILTER_EN suppresses the write enable for grants to address 0.
module rf_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [4*ADDR_W-1:0]   req_addr,
  input  logic [4*DATA_W-1:0]   req_data,
  input  logic                  hold,
  output logic [3:0]            gnt,
  output logic [1:0]            sel,
  output logic                  rf_we,
  output logic [ADDR_W-1:0]     rf_wa,
  output logic [DATA_W-1:0]     rf_wd
);

  logic [1:0]        ptr;
  logic [1:0]        win;
  logic [1:0]        idx;
  logic              found;
  logic              grant_ok;
  logic [ADDR_W-1:0] addr_arr [4];
  logic [DATA_W-1:0] data_arr [4];

  for (genvar g = 0; g < 4; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  // Search starts at ptr and wraps, so the most recently served requester is tried last.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign grant_ok = found && !rst && !hold;
  assign gnt      = grant_ok ? (4'b0001 << win) : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= 2'd0;
      sel   <= 2'd0;
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else if (grant_ok) begin
      ptr   <= win + 2'd1;
      sel   <= win;
      rf_wa <= addr_arr[win];
      rf_wd <= data_arr[win];
`ifdef RF_ARB_ZERO_FILTER_EN
      // The grant still consumes the request; only the write to $zero is dropped.
      rf_we <= (addr_arr[win] != '0);
`else
      rf_we <= 1'b1;
`endif
    end else begin
      rf_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed, table-driven bench for rf_write_arbiter: grant rotation, hold, reset and the zero-address case.
module tb_rf_write_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [3:0]          req = 4'b0000;
  logic [4*ADDR_W-1:0] req_addr = '0;
  logic [4*DATA_W-1:0] req_data = '0;
  logic                hold = 1'b0;
  logic [3:0]          gnt;
  logic [1:0]          sel;
  logic                rf_we;
  logic [ADDR_W-1:0]   rf_wa;
  logic [DATA_W-1:0]   rf_wd;

  int checks   = 0;
  int failures = 0;

  rf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .hold     (hold),
    .gnt      (gnt),
    .sel      (sel),
    .rf_we    (rf_we),
    .rf_wa    (rf_wa),
    .rf_wd    (rf_wd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        hold;
    logic [3:0]  req;
    logic        zaddr;
    logic [3:0]  gnt;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [1:0]  sel;
  } vec_t;

  localparam logic [31:0] D0 = 32'hDEAD_BEEF;
  localparam logic [31:0] D1 = 32'h1111_1111;
  localparam logic [31:0] D2 = 32'h2222_2222;
  localparam logic [31:0] D3 = 32'h3333_3333;

`ifdef RF_ARB_ZERO_FILTER_EN
  localparam logic ZERO_WE = 1'b0;
`else
  localparam logic ZERO_WE = 1'b1;
`endif

  vec_t vecs [22];

  task automatic applyStimulus(input vec_t v);
    rst  = v.rst;
    hold = v.hold;
    req  = v.req;
    req_addr = {5'd11, 5'd10, 5'd9, (v.zaddr ? 5'd0 : 5'd8)};
    req_data = {D3, D2, D1, (v.zaddr ? 32'h0000_0001 : D0)};
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    // rst, hold, req, zaddr | gnt, we, wa, wd, sel (registered values after the edge)
    vecs[0]  = '{1'b1, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 5'd0,  32'h0, 2'd0};
    vecs[1]  = '{1'b0, 1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 5'd8,  D0,    2'd0};
    vecs[2]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, 5'd9,  D1,    2'd1};
    vecs[3]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1, 5'd10, D2,    2'd2};
    vecs[4]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b1000, 1'b1, 5'd11, D3,    2'd3};
    vecs[5]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 5'd8,  D0,    2'd0};
    vecs[6]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, 5'd9,  D1,    2'd1};
    vecs[7]  = '{1'b0, 1'b0, 4'b1010, 1'b0, 4'b1000, 1'b1, 5'd11, D3,    2'd3};
    vecs[8]  = '{1'b0, 1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 5'd9,  D1,    2'd1};
    vecs[9]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 5'd9,  D1,    2'd1};
    vecs[10] = '{1'b0, 1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 5'd9,  D1,    2'd1};
    vecs[11] = '{1'b0, 1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 5'd9,  D1,    2'd1};
    vecs[12] = '{1'b0, 1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 5'd9,  D1,    2'd1};
    vecs[13] = '{1'b0, 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 5'd10, D2,    2'd2};
    vecs[14] = '{1'b0, 1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 5'd8,  D0,    2'd0};
    vecs[15] = '{1'b0, 1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 5'd8,  D0,    2'd0};
    vecs[16] = '{1'b0, 1'b0, 4'b0001, 1'b1, 4'b0001, ZERO_WE, 5'd0, 32'h1, 2'd0};
    vecs[17] = '{1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 5'd0,  32'h1, 2'd0};
    vecs[18] = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, 5'd9,  D1,    2'd1};
    vecs[19] = '{1'b1, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 5'd0,  32'h0, 2'd0};
    vecs[20] = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 5'd8,  D0,    2'd0};
    vecs[21] = '{1'b0, 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 5'd10, D2,    2'd2};

    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d rf_we", i), 32'(rf_we), 32'(vecs[i].we));
      checkOutput($sformatf("vec%0d rf_wa", i), 32'(rf_wa), 32'(vecs[i].wa));
      checkOutput($sformatf("vec%0d rf_wd", i), rf_wd, vecs[i].wd);
      checkOutput($sformatf("vec%0d sel", i), 32'(sel), 32'(vecs[i].sel));
      @(negedge clk);
    end

    // All four requesting for 8 cycles straight out of reset: strict rotation, one write per cycle.
    applyStimulus('{1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 5'd0, 32'h0, 2'd0});
    @(negedge clk);
    for (int c = 0; c < 8; c++) begin
      applyStimulus('{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 5'd0, 32'h0, 2'd0});
      #1;
      checkOutput($sformatf("rot%0d gnt", c), 32'(gnt), 32'(4'b0001 << (c % 4)));
      @(posedge clk);
      #1;
      checkOutput($sformatf("rot%0d sel", c), 32'(sel), 32'(c % 4));
      checkOutput($sformatf("rot%0d rf_we", c), 32'(rf_we), 32'd1);
      checkOutput($sformatf("rot%0d rf_wa", c), 32'(rf_wa), 32'(8 + (c % 4)));
      @(negedge clk);
    end

    req = 4'b0000;
    @(posedge clk);
    #1;
    checkOutput("idle rf_we", 32'(rf_we), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
